// File: rtl/mmu_sequencer.sv
// Command sequencer for one 2x2 systolic matrix-multiply pass: weight load, skewed
// row feed from the input buffer, pipeline drain, then a store strobe to the unified buffer.
module mmu_sequencer #(
    parameter int WADDR_W      = 13,
    parameter int IADDR_W      = 6,
    parameter int OADDR_W      = 6,
    parameter int ROWS_W       = 4,
    parameter int DATA_W       = 16,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WADDR_W-1:0] cmd_waddr,
    input  logic [IADDR_W-1:0] cmd_iaddr,
    input  logic [OADDR_W-1:0] cmd_oaddr,
    input  logic [ROWS_W-1:0]  cmd_rows,
    output logic [IADDR_W-1:0] in_rd_addr,
    input  logic [DATA_W-1:0]  in_rd_data1,
    input  logic [DATA_W-1:0]  in_rd_data2,
    output logic [WADDR_W-1:0] weight_addr,
    output logic               load_weight,
    output logic               valid,
    output logic [DATA_W-1:0]  a_in1,
    output logic [DATA_W-1:0]  a_in2,
    output logic               store_en,
    output logic [OADDR_W-1:0] store_addr,
    output logic               busy,
    output logic               done,
    output logic               cmd_rejected
);

    localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, LOAD_W, FEED, DRAIN, STORE, DONE} state_t;

    state_t              state;
    logic [ROWS_W:0]     row_cnt;
    logic [ROWS_W-1:0]   rows_q;
    logic [IADDR_W-1:0]  iaddr_q;
    logic [OADDR_W-1:0]  oaddr_q;
    logic [DCNT_W-1:0]   drain_cnt;
    logic [DATA_W-1:0]   in_data2_p1;
    logic                last_row;

    assign last_row = (row_cnt == {1'b0, rows_q});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            row_cnt     <= '0;
            rows_q      <= '0;
            iaddr_q     <= '0;
            oaddr_q     <= '0;
            drain_cnt   <= '0;
            in_data2_p1 <= '0;
            in_rd_addr  <= '0;
            weight_addr <= '0;
            store_addr  <= '0;
            load_weight <= 1'b0;
            valid       <= 1'b0;
            store_en    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            load_weight <= 1'b0;
            store_en    <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rows_q  <= cmd_rows;
                        iaddr_q <= cmd_iaddr;
                        oaddr_q <= cmd_oaddr;
                        busy    <= 1'b1;
                        if (cmd_rows == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= LOAD_W;
                            load_weight <= 1'b1;
                            weight_addr <= cmd_waddr;
                        end
                    end
                end
                LOAD_W: begin
                    state      <= FEED;
                    valid      <= 1'b1;
                    row_cnt    <= '0;
                    in_rd_addr <= iaddr_q;
                end
                FEED: begin
                    // column-1 data is delayed one cycle to give the array its skew
                    in_data2_p1 <= in_rd_data2;
                    if (last_row) begin
                        valid     <= 1'b0;
                        drain_cnt <= '0;
                        if (DRAIN_CYCLES == 0) begin
                            state      <= STORE;
                            store_en   <= 1'b1;
                            store_addr <= oaddr_q;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        row_cnt    <= row_cnt + 1'b1;
                        in_rd_addr <= in_rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state      <= STORE;
                        store_en   <= 1'b1;
                        store_addr <= oaddr_q;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                STORE: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // The trailing FEED cycle flushes row 1 only, so row 0 is blanked there.
    assign a_in1        = (valid && !last_row) ? in_rd_data1 : '0;
    assign a_in2        = (valid && row_cnt != '0) ? in_data2_p1 : '0;
    assign cmd_rejected = start & busy;

endmodule

// File: tb/tb_mmu_sequencer.sv
// Bench for mmu_sequencer: directed and randomized passes against a cycle-schedule model.
module tb_mmu_sequencer;

    localparam int WADDR_W = 13;
    localparam int IADDR_W = 6;
    localparam int OADDR_W = 6;
    localparam int ROWS_W  = 4;
    localparam int DATA_W  = 16;
    localparam int D       = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [WADDR_W-1:0] cmd_waddr;
    logic [IADDR_W-1:0] cmd_iaddr;
    logic [OADDR_W-1:0] cmd_oaddr;
    logic [ROWS_W-1:0]  cmd_rows;
    logic [IADDR_W-1:0] in_rd_addr;
    logic [DATA_W-1:0]  in_rd_data1;
    logic [DATA_W-1:0]  in_rd_data2;
    logic [WADDR_W-1:0] weight_addr;
    logic               load_weight;
    logic               valid;
    logic [DATA_W-1:0]  a_in1;
    logic [DATA_W-1:0]  a_in2;
    logic               store_en;
    logic [OADDR_W-1:0] store_addr;
    logic               busy;
    logic               done;
    logic               cmd_rejected;

    logic [DATA_W-1:0] mem1 [64];
    logic [DATA_W-1:0] mem2 [64];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign in_rd_data1 = mem1[in_rd_addr];
    assign in_rd_data2 = mem2[in_rd_addr];

    mmu_sequencer #(
        .WADDR_W(WADDR_W), .IADDR_W(IADDR_W), .OADDR_W(OADDR_W),
        .ROWS_W(ROWS_W), .DATA_W(DATA_W), .DRAIN_CYCLES(D)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .cmd_waddr(cmd_waddr), .cmd_iaddr(cmd_iaddr), .cmd_oaddr(cmd_oaddr), .cmd_rows(cmd_rows),
        .in_rd_addr(in_rd_addr), .in_rd_data1(in_rd_data1), .in_rd_data2(in_rd_data2),
        .weight_addr(weight_addr), .load_weight(load_weight), .valid(valid),
        .a_in1(a_in1), .a_in2(a_in2), .store_en(store_en), .store_addr(store_addr),
        .busy(busy), .done(done), .cmd_rejected(cmd_rejected)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".load_weight"}, 32'(load_weight), 0);
        chk({tag, ".valid"}, 32'(valid), 0);
        chk({tag, ".a_in1"}, 32'(a_in1), 0);
        chk({tag, ".a_in2"}, 32'(a_in2), 0);
        chk({tag, ".store_en"}, 32'(store_en), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".in_rd_addr"}, 32'(in_rd_addr), 0);
        chk({tag, ".weight_addr"}, 32'(weight_addr), 0);
        chk({tag, ".store_addr"}, 32'(store_addr), 0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issues one command in the next (idle) cycle and checks every cycle of its schedule.
    // rej_c: cycle at which a competing start is injected (0 = none); hold: start stays high.
    task automatic run_pass(input int wa, input int ia, input int oa, input int n,
                            input int rej_c, input bit hold);
        int len, k, e_a1, e_a2;
        bit e_val;
        len = (n == 0) ? 1 : n + 4 + D;
        next_cycle();
        start     = 1'b1;
        cmd_waddr = WADDR_W'(wa);
        cmd_iaddr = IADDR_W'(ia);
        cmd_oaddr = OADDR_W'(oa);
        cmd_rows  = ROWS_W'(n);
        #3;
        chk("c0.busy", 32'(busy), 0);
        chk("c0.cmd_rejected", 32'(cmd_rejected), 0);
        for (int c = 1; c <= len; c++) begin
            next_cycle();
            start = hold || (c == rej_c);
            if (c == rej_c) begin
                cmd_waddr = ~cmd_waddr;
                cmd_iaddr = cmd_iaddr + 6'd7;
                cmd_oaddr = ~cmd_oaddr;
                cmd_rows  = 4'd1;
            end
            #3;
            k     = c - 2;
            e_val = (n != 0) && (c >= 2) && (c <= n + 2);
            e_a1  = (e_val && k < n) ? int'(mem1[(ia + k) % 64]) : 0;
            e_a2  = (e_val && k > 0) ? int'(mem2[(ia + k - 1) % 64]) : 0;
            chk("load_weight", 32'(load_weight), 32'((n != 0) && (c == 1)));
            chk("valid", 32'(valid), 32'(e_val));
            chk("a_in1", 32'(a_in1), 32'(e_a1));
            chk("a_in2", 32'(a_in2), 32'(e_a2));
            chk("store_en", 32'(store_en), 32'((n != 0) && (c == n + 3 + D)));
            chk("done", 32'(done), 32'(c == len));
            chk("busy", 32'(busy), 1);
            chk("cmd_rejected", 32'(cmd_rejected), 32'(start));
            if (n != 0) chk("weight_addr", 32'(weight_addr), 32'(wa % 8192));
            if (e_val) chk("in_rd_addr", 32'(in_rd_addr), 32'((ia + k) % 64));
            if ((n != 0) && (c == n + 3 + D)) chk("store_addr", 32'(store_addr), 32'(oa % 64));
        end
        if (!hold) start = 1'b0;
    endtask

    task automatic idle_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            next_cycle();
            #3;
            chk("idle.busy", 32'(busy), 0);
            chk("idle.load_weight", 32'(load_weight), 0);
            chk("idle.store_en", 32'(store_en), 0);
            chk("idle.done", 32'(done), 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem1[i] = DATA_W'($urandom) | 16'h0001;
            mem2[i] = DATA_W'($urandom) | 16'h0001;
        end
        reset = 1'b1;
        start = 1'b0;
        cmd_waddr = '0;
        cmd_iaddr = '0;
        cmd_oaddr = '0;
        cmd_rows  = '0;
        repeat (2) @(posedge clk);
        #4;
        chk_all_zero("reset");
        chk("reset.cmd_rejected", 32'(cmd_rejected), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // basic pass with the documented rows
        mem1[10] = 16'd1; mem2[10] = 16'd2;
        mem1[11] = 16'd3; mem2[11] = 16'd4;
        run_pass(5, 10, 3, 2, 0, 1'b0);
        idle_check(2);

        // zero rows
        run_pass(100, 20, 9, 0, 0, 1'b0);
        idle_check(2);

        // rejected start mid-pass; no second pass may follow
        run_pass(77, 30, 12, 3, 3, 1'b0);
        idle_check(4);

        // input address wrap
        run_pass(1, 63, 5, 3, 0, 1'b0);

        // full-length command
        run_pass(8191, 50, 63, 15, 0, 1'b0);

        // randomized commands
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 64; i++) begin
                mem1[i] = DATA_W'($urandom);
                mem2[i] = DATA_W'($urandom);
            end
            run_pass(int'($urandom_range(0, 8191)), int'($urandom_range(0, 63)),
                     int'($urandom_range(0, 63)), int'($urandom_range(0, 15)),
                     (r % 2 == 1) ? int'($urandom_range(1, 3)) : 0, 1'b0);
        end

        // asynchronous reset in the middle of FEED
        for (int i = 0; i < 64; i++) mem1[i] = mem1[i] | 16'h0001;
        next_cycle();
        start = 1'b1;
        cmd_waddr = 13'd42;
        cmd_iaddr = 6'd4;
        cmd_oaddr = 6'd8;
        cmd_rows  = 4'd4;
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            start = 1'b0;
        end
        #1;
        chk("pre_reset.valid", 32'(valid), 1);
        reset = 1'b1;
        #1;
        chk_all_zero("midreset");
        next_cycle();
        reset = 1'b0;
        idle_check(10);
        run_pass(42, 4, 8, 4, 0, 1'b0);

        // start held high: back-to-back passes, rejections on every busy cycle
        run_pass(9, 60, 1, 2, 0, 1'b1);
        run_pass(9, 60, 1, 2, 0, 1'b1);
        run_pass(9, 60, 1, 0, 0, 1'b1);
        start = 1'b0;
        idle_check(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
